// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control.
// State codes, opcodes, ALU op codes and datapath select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EX   = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_control_retire.sv
// Retired-instruction counter for the main control.
// Wraps from all-ones back to zero.
module mc_retire_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // count one retirement per enabled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Optional jump support is enabled by defining MC_JUMP_EN.
module mc_main_control
  import mc_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_operation,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  state_t state_q;
  state_t state_d;
  logic   op_known;
  logic   retire_en;

  assign state = state_q;

  // state register; reset aborts any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= state_d;
  end

  // opcodes this build can execute
  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_LW,
      OP_SW,
      OP_RTYPE,
      OP_BEQ,
      OP_ADDI: op_known = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:    op_known = 1'b1;
`endif
      default: op_known = 1'b0;
    endcase
  end

  // next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE: state_d = S_EXECUTE;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDI_EX;
`ifdef MC_JUMP_EN
          OP_J:     state_d = S_JUMP;
`endif
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_LW) ? S_MEM_READ
                                    : S_MEM_WRITE;
      S_MEM_READ:
        state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE:
        state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE: state_d = S_ALU_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // datapath controls decoded from state
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_operation = ALUOP_ADD;
    illegal_op    = 1'b0;
    retire_en     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = ~op_known;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_en  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire_en = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a     = 1'b1;
        alu_operation = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_en = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire_en     = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire_en = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  mc_retire_counter #(
    .W(RETIRE_W)
  ) u_retire (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (retire_en),
    .count(retired)
  );

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: random instruction stream vs trace model.
// Honors MC_JUMP_EN when it is defined for the build.
module tb_mc_main_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_operation;
  logic       illegal_op;
  logic [3:0] retired;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_ret = 4'd0;

  always #5 clk = ~clk;

  mc_main_control #(.RETIRE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_operation(alu_operation),
    .illegal_op   (illegal_op),
    .retired      (retired),
    .state        (state)
  );

  wire [15:0] ctrl = {pc_write, pc_write_cond, pc_source,
                      i_or_d, mem_read, mem_write, ir_write,
                      reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_operation};

  // Control table written straight from the state descriptions.
  function automatic logic [15:0] exp_ctrl(input int s,
                                           input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, a;
    logic [1:0] pcs, b, op;
    {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, a} = '0;
    {pcs, b, op} = '0;
    case (s)
      0:  begin mrd = 1; b = 2'b01; pw = mr; irw = mr; end
      1:  b = 2'b11;
      2:  begin a = 1; b = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin a = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin a = 1; op = 2'b01; pwc = 1; pcs = 2'b01; end
      9:  begin a = 1; b = 2'b10; op = 2'b11; end
      10: rw = 1;
      11: begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, pcs, iod, mrd, mwr, irw,
            rd, m2r, rw, a, b, op};
  endfunction

  task automatic check_now(input int es, input logic mr,
                           input logic ill, input string tag);
    logic [15:0] ec;
    ec = exp_ctrl(es, mr);
    checks++;
    assert (state === 4'(es)) else begin
      errors++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state, es);
    end
    checks++;
    assert (ctrl === ec) else begin
      errors++;
      $error("FAIL %s ctrl s=%0d obs=%h exp=%h",
             tag, es, ctrl, ec);
    end
    checks++;
    assert (illegal_op === ill) else begin
      errors++;
      $error("FAIL %s illegal_op obs=%b exp=%b",
             tag, illegal_op, ill);
    end
    checks++;
    assert (retired === exp_ret) else begin
      errors++;
      $error("FAIL %s retired obs=%0d exp=%0d",
             tag, retired, exp_ret);
    end
  endtask

  // One clock: drive mem_ready, check, take the edge.
  task automatic cycle(input int es, input logic mr,
                       input logic ret, input logic ill);
    mem_ready = mr;
    #1;
    check_now(es, mr, ill, "cyc");
    @(posedge clk);
    #1;
    if (ret) exp_ret = exp_ret + 4'd1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] op);
`ifdef MC_JUMP_EN
    if (op == JMP) return 1'b1;
`endif
    return op == LW || op == SW || op == RT ||
           op == BEQ || op == ADDI;
  endfunction

  // Expected cycle trace of one instruction.
  task automatic run_instr(input logic [5:0] op,
                           input int f, input int m);
    opcode = op;
    for (int i = 0; i < f; i++) cycle(0, 1'b0, 0, 0);
    cycle(0, 1'b1, 0, 0);
    if (!legal(op)) begin
      cycle(1, rb(), 0, 1);
    end else begin
      cycle(1, rb(), 0, 0);
      if (op == LW) begin
        cycle(2, rb(), 0, 0);
        for (int i = 0; i < m; i++) cycle(3, 1'b0, 0, 0);
        cycle(3, 1'b1, 0, 0);
        cycle(4, rb(), 1, 0);
      end else if (op == SW) begin
        cycle(2, rb(), 0, 0);
        for (int i = 0; i < m; i++) cycle(5, 1'b0, 0, 0);
        cycle(5, 1'b1, 1, 0);
      end else if (op == RT) begin
        cycle(6, rb(), 0, 0);
        cycle(7, rb(), 1, 0);
      end else if (op == BEQ) begin
        cycle(8, rb(), 1, 0);
      end else if (op == ADDI) begin
        cycle(9, rb(), 0, 0);
        cycle(10, rb(), 1, 0);
      end else begin
        cycle(11, rb(), 1, 0);
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = LW;
      1: o = SW;
      2: o = RT;
      3: o = BEQ;
      4: o = ADDI;
      5: o = JMP;
      default: o = 6'($urandom_range(0, 63));
    endcase
    return o;
  endfunction

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    #12;
    check_now(0, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(LW, 0, 0);
    run_instr(SW, 0, 2);
    run_instr(RT, 1, 0);
    run_instr(ADDI, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(JMP, 0, 0);

    for (int n = 0; n < 80; n++)
      run_instr(pick_op(), $urandom_range(0, 2),
                $urandom_range(0, 2));

    // abort in EXECUTE with an asynchronous reset
    opcode = RT;
    cycle(0, 1'b1, 0, 0);
    cycle(1, 1'b0, 0, 0);
    mem_ready = 1'b1;
    #1;
    check_now(6, 1'b1, 1'b0, "pre_rst");
    rst_n = 1'b0;
    exp_ret = 4'd0;
    #1;
    check_now(0, 1'b1, 1'b0, "async_rst");
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 16; n++) run_instr(RT, 0, 0);
    checks++;
    assert (retired === 4'd0) else begin
      errors++;
      $error("FAIL wrap retired obs=%0d exp=0", retired);
    end

    for (int n = 0; n < 40; n++)
      run_instr(pick_op(), $urandom_range(0, 3),
                $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
